traffic_light_ctrl: RTL

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/tlc_pkg.sv | 39 +++
 rtl/tlc_phase_timer.sv | 22 ++
 rtl/traffic_light_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: state encodings and lamp decode.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_MG  = 3'd0,
    ST_MY  = 3'd1,
    ST_ARM = 3'd2,
    ST_SG  = 3'd3,
    ST_SY  = 3'd4,
    ST_ARS = 3'd5,
    ST_FL  = 3'd6
  } tlc_state_t;

  typedef struct packed {
    logic mr;
    logic mg;
    logic my;
    logic sr;
    logic sg;
    logic sy;
  } tlc_lamps_t;

  // Flash mode shows both yellows on the lit half-period and goes fully dark on the other.
  function automatic tlc_lamps_t lamp_decode(input tlc_state_t s, input logic flash_ph);
    tlc_lamps_t l;
    l = '0;
    case (s)
      ST_MG:         begin l.mg = 1'b1; l.sr = 1'b1; end
      ST_MY:         begin l.my = 1'b1; l.sr = 1'b1; end
      ST_ARM, ST_ARS: begin l.mr = 1'b1; l.sr = 1'b1; end
      ST_SG:         begin l.mr = 1'b1; l.sg = 1'b1; end
      ST_SY:         begin l.mr = 1'b1; l.sy = 1'b1; end
      ST_FL:         begin l.my = flash_ph; l.sy = flash_ph; end
      default:       begin l.mr = 1'b1; l.sr = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: loads on phase entry, counts down on enabled ticks, rests at zero.
module tlc_phase_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] value,
  output logic          zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk) begin
    if (load)
      value <= load_val;
    else if (en && !zero)
      value <= value - 1'b1;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side intersection controller with demand-driven side phase and flashing-yellow fallback.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int TW       = 5,
  parameter int T_MG_MIN = 8,
  parameter int T_MY     = 3,
  parameter int T_AR     = 1,
  parameter int T_SG     = 6,
  parameter int T_SY     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          count_en,
  input  logic          busy,
  input  logic          side_req,
  output logic          MR,
  output logic          MG,
  output logic          MY,
  output logic          SR,
  output logic          SG,
  output logic          SY,
  output logic [2:0]    state,
  output logic [2:0]    next_state,
  output logic [TW-1:0] timer,
  output logic          req_pend
);

  localparam int MAX_DUR = 2 ** TW;

  if (T_MG_MIN < 1 || T_MG_MIN > MAX_DUR || T_MY < 1 || T_MY > MAX_DUR ||
      T_AR < 1 || T_AR > MAX_DUR || T_SG < 1 || T_SG > MAX_DUR ||
      T_SY < 1 || T_SY > MAX_DUR) begin : g_bad_duration
    $error("traffic_light_ctrl: every phase duration must lie in 1..2**TW");
  end

  tlc_state_t    state_q, state_d;
  logic          req_pend_q, req_pend_d;
  logic          flash_ph, flash_ph_d;
  logic          timer_load, timer_zero, expire;
  logic [TW-1:0] timer_load_val;
  tlc_lamps_t    lamps;

  function automatic logic [TW-1:0] dur_m1(input tlc_state_t s);
    case (s)
      ST_MG:          return TW'(T_MG_MIN - 1);
      ST_MY:          return TW'(T_MY - 1);
      ST_ARM, ST_ARS: return TW'(T_AR - 1);
      ST_SG:          return TW'(T_SG - 1);
      ST_SY:          return TW'(T_SY - 1);
      default:        return '0;
    endcase
  endfunction

  tlc_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (count_en),
    .value    (timer),
    .zero     (timer_zero)
  );

  assign expire = count_en && timer_zero;

  always_comb begin
    state_d = state_q;
    if (!busy) begin
      state_d = ST_FL;
    end else begin
      case (state_q)
        ST_MG:   if (expire && (req_pend_q || side_req)) state_d = ST_MY;
        ST_MY:   if (expire) state_d = ST_ARM;
        ST_ARM:  if (expire) state_d = ST_SG;
        ST_SG:   if (expire) state_d = ST_SY;
        ST_SY:   if (expire) state_d = ST_ARS;
        ST_ARS:  if (expire) state_d = ST_MG;
        ST_FL:   state_d = ST_ARS;
        default: state_d = ST_ARS;
      endcase
    end
  end

  always_comb begin
    timer_load     = reset || (state_d != state_q);
    timer_load_val = reset ? dur_m1(ST_ARS) : dur_m1(state_d);

    // Entering SG serves the request, so clear wins over a coincident new request.
    req_pend_d = req_pend_q;
    if (state_d == ST_SG && state_q != ST_SG)
      req_pend_d = 1'b0;
    else if (side_req && state_q != ST_SG)
      req_pend_d = 1'b1;

    flash_ph_d = 1'b1;
    if (state_q == ST_FL)
      flash_ph_d = count_en ? ~flash_ph : flash_ph;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARS;
      req_pend_q <= 1'b0;
      flash_ph   <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_pend_q <= req_pend_d;
      flash_ph   <= flash_ph_d;
    end
  end

  assign lamps      = lamp_decode(state_q, flash_ph);
  assign MR         = lamps.mr;
  assign MG         = lamps.mg;
  assign MY         = lamps.my;
  assign SR         = lamps.sr;
  assign SG         = lamps.sg;
  assign SY         = lamps.sy;
  assign state      = state_q;
  assign next_state = state_d;
  assign req_pend   = req_pend_q;

endmodule
